// File: rtl/block_issue_scheduler_pkg.sv
// Shared raytrace definitions for the block issue scheduler: table size,
// the reserved block indices and the per-pixel result entry layout.
package block_issue_scheduler_pkg;

  localparam int NUM_BLOCKS_DEFAULT = 14;
  localparam logic [3:0] NO_HIT_INDEX = 4'hF;
  localparam logic [3:0] SABER_INDEX = 4'd13;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic        hit;
    logic [3:0]  index;
    logic [31:0] t;
  } res_entry_t;

  localparam int RES_W = $bits(res_entry_t);

endpackage

// File: rtl/block_result_fifo.sv
// Per-pixel result FIFO; push and pop may coincide, even when full, because
// the popped slot is the one the push overwrites.
module block_result_fifo
  import block_issue_scheduler_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push,
  input  logic [RES_W-1:0] push_data,
  input  logic             pop,
  output logic [RES_W-1:0] head,
  output logic             not_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [RES_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign not_empty = (count != '0);

endmodule

// File: rtl/block_issue_scheduler.sv
// Issues every block-table entry per accepted pixel into the intersect pipeline
// and reduces the returning beats to the nearest hit, one result per pixel.
module block_issue_scheduler
  import block_issue_scheduler_pkg::*;
#(
  parameter int NUM_BLOCKS = NUM_BLOCKS_DEFAULT,
  parameter int RES_DEPTH  = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        px_valid_in,
  output logic        px_ready_out,
  input  logic [10:0] px_x_in,
  input  logic [9:0]  px_y_in,
  output logic [3:0]  tbl_addr_out,
  input  logic [11:0] tbl_x_in,
  input  logic [11:0] tbl_y_in,
  input  logic [13:0] tbl_z_in,
  input  logic        tbl_visible_in,
  output logic        pipe_valid_out,
  output logic [10:0] pipe_x_out,
  output logic [9:0]  pipe_y_out,
  output logic [3:0]  pipe_block_index_out,
  output logic [11:0] pipe_block_x_out,
  output logic [11:0] pipe_block_y_out,
  output logic [13:0] pipe_block_z_out,
  output logic        pipe_visible_out,
  input  logic        ret_valid_in,
  input  logic [3:0]  ret_block_index_in,
  input  logic        ret_intersect_in,
  input  logic [31:0] ret_t_in,
  input  logic [10:0] ret_x_in,
  input  logic [9:0]  ret_y_in,
  output logic        res_valid_out,
  input  logic        res_ready_in,
  output logic [10:0] res_x_out,
  output logic [9:0]  res_y_out,
  output logic        res_hit_out,
  output logic [3:0]  res_block_index_out,
  output logic [31:0] res_t_out,
  output logic        busy_out,
  output logic        err_out
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  localparam int CRW = $clog2(RES_DEPTH + 1);
  localparam logic [3:0] LAST_IDX = 4'(NUM_BLOCKS - 1);

  logic [0:0]     state;
  logic [3:0]     issue_idx;
  logic [10:0]    cur_x;
  logic [9:0]     cur_y;
  logic           ready_en;
  logic [CRW-1:0] credits;
  logic [CRW-1:0] inflight;
  logic           pipe_v;
  logic [3:0]     pipe_idx;
  logic [10:0]    pipe_x;
  logic [9:0]     pipe_y;
  logic           at_last, accept, pop;

  assign at_last      = (state == ST_ISSUE) && (issue_idx == LAST_IDX);
  assign px_ready_out = ready_en && ((state == ST_IDLE) || at_last) && (credits != '0);
  assign accept       = px_valid_in && px_ready_out;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state     <= ST_IDLE;
      issue_idx <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      ready_en  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        state     <= ST_ISSUE;
        issue_idx <= '0;
        cur_x     <= px_x_in;
        cur_y     <= px_y_in;
      end else if (state == ST_ISSUE) begin
        if (at_last) begin
          state     <= ST_IDLE;
          issue_idx <= '0;
        end else begin
          issue_idx <= issue_idx + 1'b1;
        end
      end
    end
  end

  // The stage register carries x/y so a back-to-back accept cannot relabel the last block.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pipe_v   <= 1'b0;
      pipe_idx <= '0;
      pipe_x   <= '0;
      pipe_y   <= '0;
    end else begin
      pipe_v   <= (state == ST_ISSUE);
      pipe_idx <= issue_idx;
      pipe_x   <= cur_x;
      pipe_y   <= cur_y;
    end
  end

  assign tbl_addr_out         = issue_idx;
  assign pipe_valid_out       = pipe_v;
  assign pipe_block_index_out = pipe_idx;
  assign pipe_x_out           = pipe_x;
  assign pipe_y_out           = pipe_y;
  assign pipe_block_x_out     = pipe_v ? tbl_x_in : '0;
  assign pipe_block_y_out     = pipe_v ? tbl_y_in : '0;
  assign pipe_block_z_out     = pipe_v ? tbl_z_in : '0;
  assign pipe_visible_out     = pipe_v & tbl_visible_in;

  logic [3:0]  exp_idx;
  logic        best_hit;
  logic [3:0]  best_idx;
  logic [31:0] best_t;
  logic        beat_ok, beat_bad, take, last_beat;
  res_entry_t  push_entry;
  res_entry_t  head_entry;
  logic [RES_W-1:0] head_bits;
  logic        fifo_valid;

  assign beat_ok   = ret_valid_in && (inflight != '0) && (ret_block_index_in == exp_idx);
  assign beat_bad  = ret_valid_in && !beat_ok;
  // Strict less-than keeps the earlier (lower) index on equal t.
  assign take      = ret_intersect_in && (!best_hit || (ret_t_in < best_t));
  assign last_beat = beat_ok && (exp_idx == LAST_IDX);

  always_comb begin
    push_entry       = '0;
    push_entry.x     = ret_x_in;
    push_entry.y     = ret_y_in;
    push_entry.hit   = best_hit || ret_intersect_in;
    push_entry.index = take ? ret_block_index_in : best_idx;
    push_entry.t     = take ? ret_t_in : best_t;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      exp_idx  <= '0;
      best_hit <= 1'b0;
      best_idx <= NO_HIT_INDEX;
      best_t   <= '0;
      err_out  <= 1'b0;
    end else begin
      if (beat_bad) err_out <= 1'b1;
      if (last_beat) begin
        exp_idx  <= '0;
        best_hit <= 1'b0;
        best_idx <= NO_HIT_INDEX;
        best_t   <= '0;
      end else if (beat_ok) begin
        exp_idx <= exp_idx + 1'b1;
        if (take) begin
          best_hit <= 1'b1;
          best_idx <= ret_block_index_in;
          best_t   <= ret_t_in;
        end
      end
    end
  end

  assign pop = fifo_valid && res_ready_in;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      credits  <= CRW'(RES_DEPTH);
      inflight <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
      case ({accept, last_beat})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  block_result_fifo #(.DEPTH(RES_DEPTH)) u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (last_beat),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_bits),
    .not_empty (fifo_valid)
  );

  assign head_entry          = res_entry_t'(head_bits);
  assign res_valid_out       = fifo_valid;
  assign res_x_out           = fifo_valid ? head_entry.x : '0;
  assign res_y_out           = fifo_valid ? head_entry.y : '0;
  assign res_hit_out         = fifo_valid & head_entry.hit;
  assign res_block_index_out = fifo_valid ? head_entry.index : '0;
  assign res_t_out           = fifo_valid ? head_entry.t : '0;
  assign busy_out            = (inflight != '0);

endmodule

// File: tb/tb_block_issue_scheduler.sv
// Directed bench for block_issue_scheduler: issue timing, nearest-hit reduction,
// credit limiting, back-to-back issue, protocol errors and mid-operation reset.
module tb_block_issue_scheduler;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        px_valid_in = 1'b0;
  logic        px_ready_out;
  logic [10:0] px_x_in = '0;
  logic [9:0]  px_y_in = '0;
  logic [3:0]  tbl_addr_out;
  logic [11:0] tbl_x_in;
  logic [11:0] tbl_y_in;
  logic [13:0] tbl_z_in;
  logic        tbl_visible_in;
  logic        pipe_valid_out;
  logic [10:0] pipe_x_out;
  logic [9:0]  pipe_y_out;
  logic [3:0]  pipe_block_index_out;
  logic [11:0] pipe_block_x_out;
  logic [11:0] pipe_block_y_out;
  logic [13:0] pipe_block_z_out;
  logic        pipe_visible_out;
  logic        ret_valid_in = 1'b0;
  logic [3:0]  ret_block_index_in = '0;
  logic        ret_intersect_in = 1'b0;
  logic [31:0] ret_t_in = '0;
  logic [10:0] ret_x_in = '0;
  logic [9:0]  ret_y_in = '0;
  logic        res_valid_out;
  logic        res_ready_in = 1'b0;
  logic [10:0] res_x_out;
  logic [9:0]  res_y_out;
  logic        res_hit_out;
  logic [3:0]  res_block_index_out;
  logic [31:0] res_t_out;
  logic        busy_out;
  logic        err_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] rt [14];
  logic [3:0]  tbl_addr_d = '0;

  // clock/reset block
  always #5 clk_in = ~clk_in;

  // block table model: data for address a arrives one cycle later
  always @(posedge clk_in) tbl_addr_d <= tbl_addr_out;
  assign tbl_x_in       = 12'h100 + 12'(tbl_addr_d);
  assign tbl_y_in       = 12'h200 + 12'(tbl_addr_d);
  assign tbl_z_in       = 14'h0300 + 14'(tbl_addr_d);
  assign tbl_visible_in = tbl_addr_d[0];

  block_issue_scheduler dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .px_valid_in(px_valid_in), .px_ready_out(px_ready_out),
    .px_x_in(px_x_in), .px_y_in(px_y_in),
    .tbl_addr_out(tbl_addr_out),
    .tbl_x_in(tbl_x_in), .tbl_y_in(tbl_y_in), .tbl_z_in(tbl_z_in),
    .tbl_visible_in(tbl_visible_in),
    .pipe_valid_out(pipe_valid_out), .pipe_x_out(pipe_x_out), .pipe_y_out(pipe_y_out),
    .pipe_block_index_out(pipe_block_index_out),
    .pipe_block_x_out(pipe_block_x_out), .pipe_block_y_out(pipe_block_y_out),
    .pipe_block_z_out(pipe_block_z_out), .pipe_visible_out(pipe_visible_out),
    .ret_valid_in(ret_valid_in), .ret_block_index_in(ret_block_index_in),
    .ret_intersect_in(ret_intersect_in), .ret_t_in(ret_t_in),
    .ret_x_in(ret_x_in), .ret_y_in(ret_y_in),
    .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
    .res_x_out(res_x_out), .res_y_out(res_y_out), .res_hit_out(res_hit_out),
    .res_block_index_out(res_block_index_out), .res_t_out(res_t_out),
    .busy_out(busy_out), .err_out(err_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks (all called at a falling edge)
  task automatic do_reset();
    rst_in = 1'b0;
    px_valid_in = 1'b0;
    ret_valid_in = 1'b0;
    res_ready_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic accept_pixel(input logic [10:0] x, input logic [9:0] y);
    int n = 0;
    px_x_in = x;
    px_y_in = y;
    px_valid_in = 1'b1;
    while (!px_ready_out && n < 60) begin
      @(negedge clk_in);
      n++;
    end
    check("accept_timeout", 64'(n < 60), 64'd1);
    @(negedge clk_in);
    px_valid_in = 1'b0;
  endtask

  task automatic drive_beat(input logic [3:0] idx, input logic hit, input logic [31:0] t,
                            input logic [10:0] x, input logic [9:0] y);
    ret_valid_in = 1'b1;
    ret_block_index_in = idx;
    ret_intersect_in = hit;
    ret_t_in = t;
    ret_x_in = x;
    ret_y_in = y;
    @(negedge clk_in);
    ret_valid_in = 1'b0;
    ret_intersect_in = 1'b0;
  endtask

  task automatic send_returns(input logic [10:0] x, input logic [9:0] y, input logic [13:0] mask);
    for (int k = 0; k < 14; k++) drive_beat(4'(k), mask[k], rt[k], x, y);
  endtask

  task automatic pop_result();
    res_ready_in = 1'b1;
    @(negedge clk_in);
    res_ready_in = 1'b0;
  endtask

  task automatic clear_t();
    for (int k = 0; k < 14; k++) rt[k] = 32'h0;
  endtask

  // Holds px_valid for a number of cycles and counts accepts (x increments per accept).
  task automatic offer(input int cycles, input logic [10:0] x0, output int acc);
    acc = 0;
    px_valid_in = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      px_x_in = x0 + 11'(acc);
      px_y_in = 10'(acc);
      if (px_ready_out && acc < 10) acc++;
      else if (acc >= 10) px_valid_in = 1'b0;
      @(negedge clk_in);
    end
    px_valid_in = 1'b0;
  endtask

  logic        pv [48];
  logic [3:0]  pi [48];
  logic [10:0] pxs [48];

  initial begin
    int acc;
    int first, run, total, quiet;
    clear_t();

    // reset state
    repeat (3) @(negedge clk_in);
    check("rst_ready", 64'(px_ready_out), 64'd0);
    check("rst_pipe_valid", 64'(pipe_valid_out), 64'd0);
    check("rst_res_valid", 64'(res_valid_out), 64'd0);
    check("rst_busy", 64'(busy_out), 64'd0);
    check("rst_err", 64'(err_out), 64'd0);
    check("rst_addr", 64'(tbl_addr_out), 64'd0);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("ready_after_rst", 64'(px_ready_out), 64'd1);

    // single pixel (5,7): issue timing then block 3 the only hit
    accept_pixel(11'd5, 10'd7);
    check("a1_addr0", 64'(tbl_addr_out), 64'd0);
    check("a1_no_valid", 64'(pipe_valid_out), 64'd0);
    check("a1_busy", 64'(busy_out), 64'd1);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk_in);
      check("issue_valid", 64'(pipe_valid_out), 64'd1);
      check("issue_index", 64'(pipe_block_index_out), 64'(k));
      check("issue_blk_x", 64'(pipe_block_x_out), 64'(12'h100 + 12'(k)));
      check("issue_blk_z", 64'(pipe_block_z_out), 64'(14'h0300 + 14'(k)));
      check("issue_visible", 64'(pipe_visible_out), 64'(k % 2));
      if (k == 0) begin
        check("issue_x", 64'(pipe_x_out), 64'd5);
        check("issue_y", 64'(pipe_y_out), 64'd7);
      end
    end
    @(negedge clk_in);
    check("issue_end_valid", 64'(pipe_valid_out), 64'd0);
    rt[3] = 32'h40A00000;
    send_returns(11'd5, 10'd7, 14'h0008);
    check("p1_valid", 64'(res_valid_out), 64'd1);
    check("p1_hit", 64'(res_hit_out), 64'd1);
    check("p1_index", 64'(res_block_index_out), 64'd3);
    check("p1_t", 64'(res_t_out), 64'h40A00000);
    check("p1_x", 64'(res_x_out), 64'd5);
    check("p1_y", 64'(res_y_out), 64'd7);
    pop_result();
    check("p1_popped", 64'(res_valid_out), 64'd0);

    // blocks 2 and 9: nearer t wins, then equal t keeps lower index
    clear_t();
    accept_pixel(11'd20, 10'd21);
    rt[2] = 32'h41200000; rt[9] = 32'h40000000;
    send_returns(11'd20, 10'd21, 14'h0204);
    check("near_index", 64'(res_block_index_out), 64'd9);
    check("near_t", 64'(res_t_out), 64'h40000000);
    pop_result();
    accept_pixel(11'd22, 10'd23);
    rt[2] = 32'h40400000; rt[9] = 32'h40400000;
    send_returns(11'd22, 10'd23, 14'h0204);
    check("tie_index", 64'(res_block_index_out), 64'd2);
    check("tie_hit", 64'(res_hit_out), 64'd1);
    pop_result();

    // no hit at all (t values present but intersect low)
    rt[5] = 32'h3F800000;
    accept_pixel(11'd30, 10'd31);
    send_returns(11'd30, 10'd31, 14'h0000);
    check("miss_hit", 64'(res_hit_out), 64'd0);
    check("miss_index", 64'(res_block_index_out), 64'hF);
    check("miss_t", 64'(res_t_out), 64'd0);
    check("miss_x", 64'(res_x_out), 64'd30);
    pop_result();
    clear_t();

    // credit limit with the result side stalled
    offer(200, 11'd100, acc);
    check("credit_accepts", 64'(acc), 64'd8);
    check("credit_ready_low", 64'(px_ready_out), 64'd0);
    for (int i = 0; i < 8; i++) send_returns(11'd100 + 11'(i), 10'(i), 14'h0000);
    check("full_valid", 64'(res_valid_out), 64'd1);
    check("full_ready_low", 64'(px_ready_out), 64'd0);
    check("order_0", 64'(res_x_out), 64'd100);
    pop_result();
    offer(40, 11'd200, acc);
    check("one_more_accept", 64'(acc), 64'd1);
    check("one_more_ready_low", 64'(px_ready_out), 64'd0);
    for (int i = 1; i < 8; i++) begin
      check("order_x", 64'(res_x_out), 64'(100 + i));
      check("order_y", 64'(res_y_out), 64'(i));
      pop_result();
    end
    send_returns(11'd200, 10'd0, 14'h0000);
    check("late_x", 64'(res_x_out), 64'd200);
    pop_result();
    check("drained_valid", 64'(res_valid_out), 64'd0);
    check("drained_busy", 64'(busy_out), 64'd0);

    // two back-to-back pixels
    do_reset();
    fork
      begin
        accept_pixel(11'd1, 10'd1);
        accept_pixel(11'd2, 10'd2);
      end
      begin
        for (int c = 0; c < 48; c++) begin
          @(negedge clk_in);
          pv[c] = pipe_valid_out;
          pi[c] = pipe_block_index_out;
          pxs[c] = pipe_x_out;
        end
      end
    join
    first = -1; run = 0; total = 0;
    for (int c = 0; c < 48; c++) begin
      if (pv[c]) total++;
      if (pv[c] && first < 0) first = c;
    end
    if (first >= 0) while (first + run < 48 && pv[first + run]) run++;
    check("b2b_run", 64'(run), 64'd28);
    check("b2b_total", 64'(total), 64'd28);
    if (first >= 0 && run == 28) begin
      for (int k = 0; k < 28; k++) check("b2b_index", 64'(pi[first + k]), 64'(k % 14));
      check("b2b_x_last_first", 64'(pxs[first + 13]), 64'd1);
      check("b2b_x_first_second", 64'(pxs[first + 14]), 64'd2);
    end

    // out-of-order return index sets a sticky error
    do_reset();
    accept_pixel(11'd3, 10'd3);
    drive_beat(4'd0, 1'b0, 32'h0, 11'd3, 10'd3);
    drive_beat(4'd1, 1'b0, 32'h0, 11'd3, 10'd3);
    check("err_before", 64'(err_out), 64'd0);
    drive_beat(4'd3, 1'b1, 32'h1, 11'd3, 10'd3);
    check("err_set", 64'(err_out), 64'd1);
    repeat (5) @(negedge clk_in);
    check("err_sticky", 64'(err_out), 64'd1);
    do_reset();
    check("err_cleared", 64'(err_out), 64'd0);
    drive_beat(4'd0, 1'b1, 32'h1, 11'd0, 10'd0);
    check("err_stray_beat", 64'(err_out), 64'd1);

    // reset during issue discards the pixel
    do_reset();
    accept_pixel(11'd9, 10'd9);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("midrst_pipe_valid", 64'(pipe_valid_out), 64'd0);
    check("midrst_ready", 64'(px_ready_out), 64'd0);
    check("midrst_busy", 64'(busy_out), 64'd0);
    rst_in = 1'b1;
    quiet = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_in);
      if (pipe_valid_out || res_valid_out) quiet++;
    end
    check("midrst_no_output", 64'(quiet), 64'd0);
    offer(150, 11'd50, acc);
    check("midrst_credits", 64'(acc), 64'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_issue_scheduler.md
BLOCK_ISSUE_SCHEDULER -- requirements
Module: block_issue_scheduler

Interface
REQ-001 SHALL have parameter NUM_BLOCKS, default 14, the number of block-table entries issued per pixel (2..15).
REQ-002 SHALL have parameter RES_DEPTH, default 8, the result FIFO depth in pixels and the in-flight credit limit.
REQ-003 SHALL have port clk_in, input, 1 bit, the single clock.
REQ-004 SHALL have port rst_in, input, 1 bit, a synchronous active-low reset.
REQ-005 SHALL have ports px_valid_in (input, 1), px_ready_out (output, 1), px_x_in (input, 11) and px_y_in (input, 10), forming the pixel request handshake.
REQ-006 SHALL have port tbl_addr_out, output, 4 bits, the block-table read address.
REQ-007 SHALL have ports tbl_x_in (input, 12), tbl_y_in (input, 12), tbl_z_in (input, 14) and tbl_visible_in (input, 1), carrying table data 1 cycle after the address.
REQ-008 SHALL have ports pipe_valid_out (output, 1), pipe_x_out (output, 11), pipe_y_out (output, 10), pipe_block_index_out (output, 4), pipe_block_x_out (output, 12), pipe_block_y_out (output, 12), pipe_block_z_out (output, 14) and pipe_visible_out (output, 1), the issue side of the intersect pipeline.
REQ-009 SHALL have ports ret_valid_in (input, 1), ret_block_index_in (input, 4), ret_intersect_in (input, 1), ret_t_in (input, 32, float) and ret_x_in / ret_y_in (input, 11/10), the pipeline return side.
REQ-010 SHALL have ports res_valid_out (output, 1), res_ready_in (input, 1), res_x_out (output, 11), res_y_out (output, 10), res_hit_out (output, 1), res_block_index_out (output, 4) and res_t_out (output, 32), the per-pixel result handshake.
REQ-011 SHALL have ports busy_out (output, 1), high while any pixel is issuing or in flight, and err_out (output, 1), a sticky protocol-error flag.

Function
REQ-012 SHALL run an issue FSM with states IDLE and ISSUE: IDLE->ISSUE on accept; ISSUE->IDLE after index NUM_BLOCKS-1 unless a new pixel is accepted in that same cycle, in which case it stays in ISSUE.
REQ-013 SHALL assert px_ready_out only when (state==IDLE or issue index==NUM_BLOCKS-1) and credits>0.
REQ-014 SHALL, for a pixel accepted in cycle A, drive tbl_addr_out=k in cycle A+1+k and assert pipe_valid_out with block k, the latched x/y and the table data in cycle A+2+k, for k=0..NUM_BLOCKS-1.
REQ-015 SHALL issue back-to-back pixels with no bubble between them, and SHALL hold pipe_valid_out low at all other times.
REQ-016 SHALL hold credits initialised to RES_DEPTH: decrement on pixel accept, increment on result pop (res_valid_out&&res_ready_in), unchanged when both occur in the same cycle, and never exceeding RES_DEPTH or going below 0.
REQ-017 SHALL expect returns as contiguous beats with index 0..NUM_BLOCKS-1 in order, and SHALL set err_out on an index mismatch or on a beat arriving while no pixel is outstanding; such a beat is dropped.
REQ-018 SHALL reduce each pixel's beats: a beat is a candidate iff ret_intersect_in=1; it replaces the best if none is held yet or if ret_t_in < best t as a 32-bit unsigned compare (valid because t>=0); ties keep the lower index.
REQ-019 SHALL push {x, y, hit, index, t} into the FIFO on the last beat; with no hit, the entry SHALL carry hit=0, index=4'hF and t=0.
REQ-020 SHALL present the FIFO head as res_* and raise res_valid_out the cycle after the push when the FIFO was empty; ordering is FIFO.
REQ-021 SHALL accept a FIFO push and pop in the same cycle, including when the FIFO is full, where this is legal because credits guarantee no overflow.

Reset
REQ-022 SHALL, on rst_in=0 at a clock edge, return the FSM to IDLE, set credits=RES_DEPTH, empty the FIFO, clear the accumulator and err_out, and drive every output to 0 (px_ready_out then rises the cycle after reset deasserts).
REQ-023 SHALL discard any in-progress issue or reduction when reset occurs mid-operation, with no partial result emitted.

Structure
REQ-024 SHALL place NUM_BLOCKS default, NO_HIT_INDEX=4'hF, SABER_INDEX=13 and the result struct type in the shared raytrace package.
REQ-025 SHALL implement the result FIFO as sub-module block_result_fifo, parameterised by depth, with same-cycle push/pop support.

Verification
REQ-026 SHALL verify single pixel (5,7) with only block 3 intersecting at t=0x40A00000 -> res hit=1, index=3, t=0x40A00000, x=5, y=7.
REQ-027 SHALL verify blocks 2 and 9 both intersecting with t=0x41200000 and 0x40000000 -> index=9; with equal t -> index=2.
REQ-028 SHALL verify no intersecting block -> hit=0, index=4'hF, t=0.
REQ-029 SHALL verify res_ready_in=0 with 10 pixels offered -> exactly 8 accepted and px_ready_out=0 afterwards; a single pop lets exactly one more pixel be accepted.
REQ-030 SHALL verify two back-to-back pixels -> 28 consecutive pipe_valid_out cycles with indices 0..13,0..13.
REQ-031 SHALL verify return indices 0,1,3 -> err_out=1 and sticky until reset; reset mid-issue -> no result emitted and credits=RES_DEPTH.
